// File: rtl/pong_ctrl.sv
// rtl/pong_ctrl.sv - two-player pong game controller on a 64x64 field
// Ball, paddle and score state advance on each tick pulse; all outputs are registered.
module pong_ctrl #(
    parameter int SERVE_TICKS = 16,
    parameter int POINT_TICKS = 32,
    parameter int WIN_SCORE   = 7,
    parameter int PADDLE_H    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [5:0] bx,
    output logic [5:0] by,
    output logic [5:0] p1y,
    output logic [5:0] p2y,
    output logic [2:0] sc1,
    output logic [2:0] sc2,
    output logic [1:0] winner,
    output logic       frame_done
);

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAMEOVER} state_t;

    localparam logic [5:0]  PMAX      = 6'(64 - PADDLE_H);
    localparam logic [15:0] SERVE_END = 16'(SERVE_TICKS);
    localparam logic [15:0] POINT_END = 16'(POINT_TICKS);
    localparam logic [2:0]  WIN       = 3'(WIN_SCORE);

    state_t      state, state_n;
    logic [5:0]  bx_n, by_n, p1y_n, p2y_n;
    logic [2:0]  sc1_n, sc2_n;
    logic [1:0]  winner_n;
    logic        frame_done_n;
    logic        dx, dx_n, dy, dy_n;
    logic        serve_left, serve_left_n;
    logic [15:0] cnt, cnt_n;
    logic        enter_serve, miss;

    function automatic logic [5:0] paddle_step(input logic [5:0] p, input logic up, input logic dn);
        logic [5:0] r;
        r = p;
        if (up && !dn && p != 6'd0)
            r = p - 6'd1;
        else if (dn && !up && p < PMAX)
            r = p + 6'd1;
        return r;
    endfunction

    function automatic logic on_paddle(input logic [5:0] row, input logic [5:0] top);
        logic [6:0] bottom;
        bottom = {1'b0, top} + 7'(PADDLE_H - 1);
        return (row >= top) && ({1'b0, row} <= bottom);
    endfunction

    always_comb begin
        state_n      = state;
        bx_n         = bx;
        by_n         = by;
        p1y_n        = p1y;
        p2y_n        = p2y;
        sc1_n        = sc1;
        sc2_n        = sc2;
        winner_n     = winner;
        dx_n         = dx;
        dy_n         = dy;
        serve_left_n = serve_left;
        cnt_n        = cnt;
        frame_done_n = tick;
        enter_serve  = 1'b0;
        miss         = 1'b0;

        case (state)
            IDLE, GAMEOVER: begin
                if (start) begin
                    sc1_n        = 3'd0;
                    sc2_n        = 3'd0;
                    winner_n     = 2'b00;
                    serve_left_n = 1'b0;
                    enter_serve  = 1'b1;
                end
            end
            SERVE: begin
                if (tick) begin
                    p1y_n = paddle_step(p1y, p1_up, p1_dn);
                    p2y_n = paddle_step(p2y, p2_up, p2_dn);
                    cnt_n = cnt + 16'd1;
                    if (cnt_n == SERVE_END)
                        state_n = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    p1y_n = paddle_step(p1y, p1_up, p1_dn);
                    p2y_n = paddle_step(p2y, p2_up, p2_dn);
                    bx_n  = dx ? bx + 6'd1 : bx - 6'd1;
                    // Collision uses the paddle rows as they stood before this tick.
                    if (bx == 6'd2 && !dx) begin
                        if (on_paddle(by, p1y)) begin
                            dx_n = 1'b1;
                            bx_n = 6'd3;
                        end else begin
                            miss         = 1'b1;
                            sc2_n        = (sc2 == 3'd7) ? sc2 : sc2 + 3'd1;
                            serve_left_n = 1'b1;
                        end
                    end else if (bx == 6'd61 && dx) begin
                        if (on_paddle(by, p2y)) begin
                            dx_n = 1'b0;
                            bx_n = 6'd60;
                        end else begin
                            miss         = 1'b1;
                            sc1_n        = (sc1 == 3'd7) ? sc1 : sc1 + 3'd1;
                            serve_left_n = 1'b0;
                        end
                    end
                    if (miss) begin
                        bx_n    = bx;
                        state_n = POINT;
                        cnt_n   = 16'd0;
                    end else if (by == 6'd0 && !dy) begin
                        dy_n = 1'b1;
                        by_n = 6'd1;
                    end else if (by == 6'd63 && dy) begin
                        dy_n = 1'b0;
                        by_n = 6'd62;
                    end else begin
                        by_n = dy ? by + 6'd1 : by - 6'd1;
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    cnt_n = cnt + 16'd1;
                    if (cnt_n == POINT_END) begin
                        if (sc1 == WIN) begin
                            winner_n = 2'b01;
                            state_n  = GAMEOVER;
                        end else if (sc2 == WIN) begin
                            winner_n = 2'b10;
                            state_n  = GAMEOVER;
                        end else begin
                            enter_serve = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Serve travels toward whoever lost the last point; a fresh game serves right.
        if (enter_serve) begin
            state_n = SERVE;
            bx_n    = 6'd31;
            by_n    = 6'd31;
            dy_n    = 1'b1;
            dx_n    = ~serve_left_n;
            cnt_n   = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bx         <= 6'd31;
            by         <= 6'd31;
            p1y        <= 6'd29;
            p2y        <= 6'd29;
            sc1        <= 3'd0;
            sc2        <= 3'd0;
            winner     <= 2'b00;
            frame_done <= 1'b0;
            dx         <= 1'b1;
            dy         <= 1'b1;
            serve_left <= 1'b0;
            cnt        <= 16'd0;
        end else begin
            state      <= state_n;
            bx         <= bx_n;
            by         <= by_n;
            p1y        <= p1y_n;
            p2y        <= p2y_n;
            sc1        <= sc1_n;
            sc2        <= sc2_n;
            winner     <= winner_n;
            frame_done <= frame_done_n;
            dx         <= dx_n;
            dy         <= dy_n;
            serve_left <= serve_left_n;
            cnt        <= cnt_n;
        end
    end

endmodule

// File: tb/tb_pong_ctrl.sv
// tb/tb_pong_ctrl.sv - randomized bench for pong_ctrl against a behavioural game model
module tb_pong_ctrl;

    localparam int ST = 16;
    localparam int PT = 32;
    localparam int WS = 7;
    localparam int PH = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, start = 1'b0;
    logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic [5:0] bx, by, p1y, p2y;
    logic [2:0] sc1, sc2;
    logic [1:0] winner;
    logic       frame_done;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // model state: 0 idle, 1 serve, 2 play, 3 point, 4 game over
    int m_st, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_w, m_cnt, m_left, m_fd;

    pong_ctrl #(.SERVE_TICKS(ST), .POINT_TICKS(PT), .WIN_SCORE(WS), .PADDLE_H(PH)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .bx(bx), .by(by), .p1y(p1y), .p2y(p2y),
        .sc1(sc1), .sc2(sc2), .winner(winner), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int padj(input int p, input int u, input int d);
        if (u != 0 && d == 0) return (p > 0) ? p - 1 : 0;
        if (d != 0 && u == 0) return (p < 64 - PH) ? p + 1 : p;
        return p;
    endfunction

    task automatic new_serve();
        m_st  = 1;
        m_bx  = 31;
        m_by  = 31;
        m_dy  = 1;
        m_cnt = 0;
        m_dx  = (m_left != 0) ? -1 : 1;
    endtask

    initial forever begin
        int o1, o2, miss;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_st = 0; m_bx = 31; m_by = 31; m_dx = 1; m_dy = 1; m_p1 = 29; m_p2 = 29;
            m_s1 = 0; m_s2 = 0; m_w = 0; m_cnt = 0; m_left = 0; m_fd = 0;
        end else begin
            m_fd = int'(tick);
            case (m_st)
                0, 4: if (start) begin
                    m_s1 = 0; m_s2 = 0; m_w = 0; m_left = 0;
                    new_serve();
                end
                1: if (tick) begin
                    m_p1 = padj(m_p1, p1_up, p1_dn);
                    m_p2 = padj(m_p2, p2_up, p2_dn);
                    m_cnt++;
                    if (m_cnt == ST) m_st = 2;
                end
                2: if (tick) begin
                    o1 = m_p1; o2 = m_p2; miss = 0;
                    m_p1 = padj(m_p1, p1_up, p1_dn);
                    m_p2 = padj(m_p2, p2_up, p2_dn);
                    if (m_bx == 2 && m_dx < 0) begin
                        if (m_by >= o1 && m_by < o1 + PH) begin m_dx = 1; m_bx = 3; end
                        else begin miss = 1; m_s2 = (m_s2 < 7) ? m_s2 + 1 : 7; m_left = 1; end
                    end else if (m_bx == 61 && m_dx > 0) begin
                        if (m_by >= o2 && m_by < o2 + PH) begin m_dx = -1; m_bx = 60; end
                        else begin miss = 1; m_s1 = (m_s1 < 7) ? m_s1 + 1 : 7; m_left = 0; end
                    end else begin
                        m_bx = m_bx + m_dx;
                    end
                    if (miss != 0) begin
                        m_st = 3; m_cnt = 0;
                    end else if (m_by == 0 && m_dy < 0) begin
                        m_dy = 1; m_by = 1;
                    end else if (m_by == 63 && m_dy > 0) begin
                        m_dy = -1; m_by = 62;
                    end else begin
                        m_by = m_by + m_dy;
                    end
                end
                3: if (tick) begin
                    m_cnt++;
                    if (m_cnt == PT) begin
                        if (m_s1 == WS) begin m_w = 1; m_st = 4; end
                        else if (m_s2 == WS) begin m_w = 2; m_st = 4; end
                        else new_serve();
                    end
                end
                default: m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("bx", bx, m_bx);
            check("by", by, m_by);
            check("p1y", p1y, m_p1);
            check("p2y", p2y, m_p2);
            check("sc1", sc1, m_s1);
            check("sc2", sc2, m_s2);
            check("winner", winner, m_w);
            check("frame_done", frame_done, m_fd);
        end
    end

    task automatic do_tick(input bit u1, input bit d1, input bit u2, input bit d2);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(posedge clk); #1;
            tick = 1'b0;
            p1_up = 1'($urandom); p1_dn = 1'($urandom); p2_up = 1'($urandom); p2_dn = 1'($urandom);
        end
        @(posedge clk); #1;
        tick = 1'b1; p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
        @(posedge clk); #1;
        tick = 1'b0;
        p1_up = 1'($urandom); p1_dn = 1'($urandom); p2_up = 1'($urandom); p2_dn = 1'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bx"}, bx, 31);
        check({tag, "_by"}, by, 31);
        check({tag, "_p1y"}, p1y, 29);
        check({tag, "_p2y"}, p2y, 29);
        check({tag, "_sc1"}, sc1, 0);
        check({tag, "_sc2"}, sc2, 0);
        check({tag, "_winner"}, winner, 0);
        check({tag, "_fd"}, frame_done, 0);
    endtask

    initial begin
        int r;
        #1 rst = 1'b1;
        #2 check_reset_values("rst0");
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;

        // p1 climbs to the top, p2 sinks to the bottom while the ball plays out.
        for (int k = 1; k <= 106; k++) begin
            do_tick(1'b1, 1'b0, 1'b0, 1'b1);
            if (k == 1) check("fd_after_tick", frame_done, 1);
            if (k == 16) begin check("play_bx", bx, 31); check("play_by", by, 31); end
            if (k == 17) begin check("step_bx", bx, 32); check("step_by", by, 32); end
            if (k == 29) check("p2y_floor", p2y, 58);
            if (k == 40) check("p1y_top", p1y, 0);
            if (k == 47) begin check("hit_bx", bx, 60); check("hit_by", by, 62); check("hit_sc1", sc1, 0); end
            if (k == 105) begin check("arrive_bx", bx, 2); check("arrive_by", by, 6); end
            if (k == 106) begin check("miss_sc2", sc2, 1); check("frozen_bx", bx, 2); check("frozen_by", by, 6); end
        end

        for (int k = 1; k <= PT; k++) begin
            do_tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (k == PT - 1) begin check("point_bx", bx, 2); check("point_by", by, 6); end
        end
        check("serve_bx", bx, 31);
        check("serve_by", by, 31);
        check("point_p1y", p1y, 0);
        check("point_p2y", p2y, 58);

        repeat (5) do_tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("p1y_down5", p1y, 5);
        repeat (5) do_tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("p1y_both", p1y, 5);
        repeat (6) do_tick(1'b0, 1'b0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("serve_left_bx", bx, 30);
        check("serve_left_by", by, 32);

        // asynchronous reset mid-play with frame_done still high
        do_tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1 check_reset_values("rst_mid");
        @(negedge clk);
        rst = 1'b0;

        for (int it = 0; it < 2500; it++) begin
            r = $urandom_range(0, 199);
            if (m_st == 0 || m_st == 4 || r < 3) begin
                @(posedge clk); #1;
                start = 1'b1; tick = 1'($urandom);
                @(posedge clk); #1;
                start = 1'b0; tick = 1'b0;
            end else if (r == 3) begin
                #3 rst = 1'b1;
                #3 rst = 1'b0;
            end else begin
                do_tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            if (m_st == 4 && it % 50 == 0)
                check("gameover_winner", winner, (m_s1 == WS) ? 1 : 2);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
